// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM encoding for the multi-ported register file.
package regfile_mp_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_sb.sv
// Busy scoreboard: one pending-write bit per register, updated by flush, issue and write-back.
module regfile_sb
    import regfile_mp_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int NWP  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NWP-1:0]      wr_en,
    input  logic [NWP*AW-1:0]   wr_addr,
    output logic [NREG-1:0]     busy
);

    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] iss_hit;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int w = 0; w < NWP; w++) begin
            if (wr_en[w]) begin
                wr_hit[wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
        if (iss_en) begin
            iss_hit[iss_addr] = 1'b1;
        end
    end

    // Priority per register: flush, then issue (set), then write-back (clear).
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (iss_hit[r]) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-through bypass, zero-fill init sweep and busy scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRP  = 2,
    parameter int NWP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    output logic                 ready,
    input  logic [NRP*AW-1:0]    rd_addr,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP-1:0]       rd_busy,
    input  logic [NWP-1:0]       wr_en,
    input  logic [NWP*AW-1:0]    wr_addr,
    input  logic [NWP*XLEN-1:0]  wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr
);

    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

    rf_state_t         state, state_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;
    logic              run;
    logic [NWP-1:0]    wr_en_g;
    logic [NREG-1:0]   busy;
    logic [XLEN-1:0]   mem [NREG];

    assign run     = (state == ST_RUN);
    assign ready   = run;
    assign wr_en_g = run ? wr_en : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Storage has no reset; the INIT sweep is the only thing that clears it.
    // Later write ports overwrite earlier ones through NBA ordering.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt] <= '0;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (wr_en_g[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_sb #(
        .NREG (NREG),
        .NWP  (NWP),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush & run),
        .iss_en   (iss_en & run),
        .iss_addr (iss_addr),
        .wr_en    (wr_en_g),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = rd_addr[p*AW +: AW];

        // Highest-index matching write port bypasses storage and hides the busy bit.
        always_comb begin
            rd = mem[ra];
            rb = busy[ra];
            for (int w = 0; w < NWP; w++) begin
                if (wr_en_g[w] && (wr_addr[w*AW +: AW] == ra)) begin
                    rd = wr_data[w*XLEN +: XLEN];
                    rb = 1'b0;
                end
            end
            if ((ra == '0) || !run) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = rd;
        assign rd_busy[p]              = rb;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp with default parameters.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 flush;
    logic                 ready;
    logic [NRP*AW-1:0]    rd_addr;
    logic [NRP*XLEN-1:0]  rd_data;
    logic [NRP-1:0]       rd_busy;
    logic [NWP-1:0]       wr_en;
    logic [NWP*AW-1:0]    wr_addr;
    logic [NWP*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRP  (NRP),
        .NWP  (NWP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int w, input int a, input logic [31:0] d);
        wr_en[w]                = 1'b1;
        wr_addr[w*AW +: AW]     = AW'(a);
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    function automatic logic [31:0] rdat(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb_q.push_back(item);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t item;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=<queued value>", obs);
        end else begin
            item = sb_q.pop_front();
            assert (obs === item.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int cycles = 0;
        while (ready !== 1'b1 && cycles < 100) begin
            if (cycles == NREG - 1) begin
                expect_val({tag, "_ready_low_last"}, 32'd0);
                check({31'd0, ready});
            end
            tick();
            cycles++;
        end
        expect_val({tag, "_init_cycles"}, 32'(NREG));
        check(32'(cycles));
    endtask

    initial begin
        rstn     = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
        idle();

        repeat (3) tick();
        expect_val("reset_ready", 32'd0);
        check({31'd0, ready});
        set_rd(0, 5);
        #1;
        expect_val("reset_rd_data", 32'd0);
        check(rdat(0));

        // Leave reset with issue/write traffic present; INIT must ignore it.
        rstn = 1'b1;
        iss_en = 1'b1;
        iss_addr = 5'd12;
        set_wr(0, 13, 32'h1234_5678);
        wait_ready("boot");
        idle();
        set_rd(0, 12);
        #1;
        expect_val("init_iss_ignored", 32'd0);
        check({31'd0, rd_busy[0]});

        for (int r = 0; r < NREG; r++) begin
            set_rd(0, r);
            set_rd(1, NREG - 1 - r);
            #1;
            expect_val($sformatf("swept_p0_x%0d", r), 32'd0);
            check(rdat(0));
            if (r == 13) begin
                expect_val("swept_p1_x18", 32'd0);
                check(rdat(1));
            end
        end

        set_rd(0, 5);
        set_wr(0, 5, 32'hDEAD_BEEF);
        #1;
        expect_val("x5_bypass", 32'hDEAD_BEEF);
        check(rdat(0));
        tick();
        idle();
        #1;
        expect_val("x5_stored", 32'hDEAD_BEEF);
        check(rdat(0));

        set_rd(0, 7);
        set_rd(1, 7);
        set_wr(0, 7, 32'h1111_1111);
        set_wr(1, 7, 32'h2222_2222);
        #1;
        expect_val("x7_bypass_p0", 32'h2222_2222);
        check(rdat(0));
        expect_val("x7_bypass_p1", 32'h2222_2222);
        check(rdat(1));
        tick();
        idle();
        #1;
        expect_val("x7_stored", 32'h2222_2222);
        check(rdat(0));

        set_wr(0, 7, 32'h3333_3333);
        wr_addr[1*AW +: AW] = 5'd7;
        wr_data[1*XLEN +: XLEN] = 32'h4444_4444;
        #1;
        expect_val("x7_disabled_p1", 32'h3333_3333);
        check(rdat(0));
        tick();
        idle();
        #1;
        expect_val("x7_stored_p0", 32'h3333_3333);
        check(rdat(0));

        set_rd(0, 0);
        set_wr(0, 0, 32'hFFFF_FFFF);
        iss_en = 1'b1;
        iss_addr = 5'd0;
        #1;
        expect_val("x0_data_same", 32'd0);
        check(rdat(0));
        expect_val("x0_busy_same", 32'd0);
        check({31'd0, rd_busy[0]});
        tick();
        idle();
        #1;
        expect_val("x0_data_next", 32'd0);
        check(rdat(0));
        expect_val("x0_busy_next", 32'd0);
        check({31'd0, rd_busy[0]});

        set_rd(0, 9);
        iss_en = 1'b1;
        iss_addr = 5'd9;
        #1;
        expect_val("x9_iss_invisible", 32'd0);
        check({31'd0, rd_busy[0]});
        tick();
        idle();
        #1;
        expect_val("x9_busy", 32'd1);
        check({31'd0, rd_busy[0]});
        set_wr(1, 9, 32'h0000_0005);
        #1;
        expect_val("x9_wr_busy_same", 32'd0);
        check({31'd0, rd_busy[0]});
        expect_val("x9_wr_data_same", 32'h0000_0005);
        check(rdat(0));
        tick();
        idle();
        #1;
        expect_val("x9_busy_after_wr", 32'd0);
        check({31'd0, rd_busy[0]});
        tick();
        expect_val("x9_busy_stays", 32'd0);
        check({31'd0, rd_busy[0]});

        set_rd(1, 11);
        iss_en = 1'b1;
        iss_addr = 5'd11;
        set_wr(0, 11, 32'h0000_00AB);
        tick();
        idle();
        #1;
        expect_val("x11_iss_beats_wr", 32'd1);
        check({31'd0, rd_busy[1]});

        iss_en = 1'b1;
        iss_addr = 5'd9;
        tick();
        iss_addr = 5'd10;
        tick();
        idle();
        set_rd(0, 9);
        set_rd(1, 10);
        #1;
        expect_val("x9_busy_pre_flush", 32'd1);
        check({31'd0, rd_busy[0]});
        expect_val("x10_busy_pre_flush", 32'd1);
        check({31'd0, rd_busy[1]});
        flush = 1'b1;
        iss_en = 1'b1;
        iss_addr = 5'd9;
        tick();
        idle();
        #1;
        expect_val("x9_flushed", 32'd0);
        check({31'd0, rd_busy[0]});
        expect_val("x10_flushed", 32'd0);
        check({31'd0, rd_busy[1]});

        set_wr(0, 3, 32'hA5A5_A5A5);
        tick();
        idle();
        iss_en = 1'b1;
        iss_addr = 5'd3;
        tick();
        idle();
        set_rd(0, 3);
        #1;
        expect_val("x3_data_pre_rst", 32'hA5A5_A5A5);
        check(rdat(0));
        expect_val("x3_busy_pre_rst", 32'd1);
        check({31'd0, rd_busy[0]});
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        expect_val("midrst_ready", 32'd0);
        check({31'd0, ready});
        expect_val("midrst_rd_data", 32'd0);
        check(rdat(0));
        wait_ready("midrst");
        #1;
        expect_val("x3_swept", 32'd0);
        check(rdat(0));
        expect_val("x3_busy_cleared", 32'd0);
        check({31'd0, rd_busy[0]});
        set_rd(0, 11);
        #1;
        expect_val("x11_busy_cleared", 32'd0);
        check({31'd0, rd_busy[0]});

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
